// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared types, default sizing and width helper for the FIFO write arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, BURST} state_e;
   localparam int N_REQ_DEF = 4;
   localparam int W_DEF = 8;
   localparam int MAX_BURST_DEF = 4;
   localparam int CNT_W_DEF = 16;
   // Never returns 0 so single-value ranges still get a usable 1-bit field.
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer handshakes plus FIFO write port and arbiter status.
interface fifo_write_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W = W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int GW = clog2(N_REQ)
);
   logic [N_REQ-1:0] req_valid;
   logic [N_REQ*W-1:0] req_data;
   logic [N_REQ-1:0] req_last;
   logic [N_REQ-1:0] req_ready;
   logic fifo_full;
   logic fifo_wr_en;
   logic [W-1:0] fifo_wr_data;
   logic [GW-1:0] grant_id;
   logic busy;
   logic [CNT_W-1:0] words_written;
   modport master (
      output req_valid, req_data, req_last, fifo_full,
      input req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, words_written
   );
   modport slave (
      input req_valid, req_data, req_last, fifo_full,
      output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy, words_written
   );
endinterface

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// rr_priority_select: picks the first set request searching upward from last_grant+1, wrapping.
module rr_priority_select
   import fifo_arb_pkg::*;
#(
   parameter int N = N_REQ_DEF,
   parameter int GW = clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last_grant,
   output logic [GW-1:0] grant,
   output logic          any_req
);
   logic [GW-1:0] idx;
   // Scan farthest-first so the nearest requester after last_grant overwrites and wins.
   always_comb begin
      grant = '0;
      idx = '0;
      for (int i = N; i >= 1; i--) begin
         idx = GW'((int'(last_grant) + i) % N);
         if (req[idx]) grant = idx;
      end
   end
   assign any_req = |req;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-granted sharing of the single FIFO write port.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int W = W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic write_clk,
   input logic reset,
   fifo_write_arbiter_if.slave bus
);
   localparam int GW = clog2(N_REQ);
   localparam int BW = clog2(MAX_BURST);
   state_e state_q, state_d;
   logic [GW-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, sel;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic [CNT_W-1:0] words_written_q, words_written_d;
   logic any_req, in_burst, owner_valid, owner_last, xfer, done;

   rr_priority_select #(.N(N_REQ), .GW(GW)) u_sel (
      .req       (bus.req_valid),
      .last_grant(last_grant_q),
      .grant     (sel),
      .any_req   (any_req)
   );

   always_comb begin
      in_burst = state_q == BURST;
      owner_valid = bus.req_valid[grant_id_q];
      owner_last = bus.req_last[grant_id_q];
      xfer = in_burst & owner_valid & ~bus.fifo_full;
      done = ~owner_valid | (xfer & (owner_last | burst_cnt_q == BW'(MAX_BURST - 1)));
      state_d = state_q;
      grant_id_d = grant_id_q;
      last_grant_d = last_grant_q;
      burst_cnt_d = burst_cnt_q;
      words_written_d = words_written_q + CNT_W'(xfer);
      if (!in_burst) begin
         if (any_req) begin
            state_d = BURST;
            grant_id_d = sel;
            burst_cnt_d = '0;
         end
      end else begin
         burst_cnt_d = burst_cnt_q + BW'(xfer);
         if (done) begin
            state_d = IDLE;
            last_grant_d = grant_id_q;
         end
      end
   end

   always_ff @(posedge write_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_id_q <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         burst_cnt_q <= '0;
         words_written_q <= '0;
      end else begin
         state_q <= state_d;
         grant_id_q <= grant_id_d;
         last_grant_q <= last_grant_d;
         burst_cnt_q <= burst_cnt_d;
         words_written_q <= words_written_d;
      end
   end

   // Only the owner's inputs reach the outputs; other requesters feed next-state logic alone.
   assign bus.req_ready = (in_burst & ~bus.fifo_full) ? N_REQ'(1) << grant_id_q : '0;
   assign bus.fifo_wr_en = xfer;
   assign bus.fifo_wr_data = xfer ? bus.req_data[grant_id_q*W +: W] : '0;
   assign bus.grant_id = grant_id_q;
   assign bus.busy = in_burst;
   assign bus.words_written = words_written_q;
endmodule
